// File: rtl/des_pkg.sv
// Shared tables, widths and state encoding for the DES key schedule.
// Optional key parity checking is enabled by defining DES_KEY_PARITY_CHECK_EN.
package des_pkg;

   localparam int HALF_W = 28;
   localparam int CD_W   = 56;
   localparam int SK_W   = 48;

   localparam logic [15:0] SHIFT_MAP_DEF = 16'h7EFC;

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_RUN,
      S_DONE
   } state_t;

   localparam int PC1_T [CD_W] = '{
      57, 49, 41, 33, 25, 17,  9,
       1, 58, 50, 42, 34, 26, 18,
      10,  2, 59, 51, 43, 35, 27,
      19, 11,  3, 60, 52, 44, 36,
      63, 55, 47, 39, 31, 23, 15,
       7, 62, 54, 46, 38, 30, 22,
      14,  6, 61, 53, 45, 37, 29,
      21, 13,  5, 28, 20, 12,  4
   };

   localparam int PC2_T [SK_W] = '{
      14, 17, 11, 24,  1,  5,
       3, 28, 15,  6, 21, 10,
      23, 19, 12,  4, 26,  8,
      16,  7, 27, 20, 13,  2,
      41, 52, 31, 37, 47, 55,
      30, 40, 51, 45, 33, 48,
      44, 49, 39, 56, 34, 53,
      46, 42, 50, 36, 29, 32
   };

   // Table entries are 1-based DES bit numbers, MSB first.
   function automatic logic [CD_W-1:0] pc1(input logic [63:0] k);
      logic [CD_W-1:0] r;
      r = '0;
      for (int i = 0; i < CD_W; i++) r[CD_W-1-i] = k[64-PC1_T[i]];
      return r;
   endfunction

   function automatic logic [HALF_W-1:0] rotl28(
      input logic [HALF_W-1:0] x,
      input logic [4:0]        n
   );
      logic [2*HALF_W-1:0] t;
      t = {x, x} << n;
      return t[2*HALF_W-1:HALF_W];
   endfunction

   function automatic logic [4:0] shift_sum(
      input logic [15:0] map,
      input int          n
   );
      int s;
      s = 0;
      for (int i = 0; i < n; i++) s += map[i] ? 2 : 1;
      return 5'(s % HALF_W);
   endfunction

endpackage

// File: rtl/des_pc2.sv
// PC-2 compression: 56-bit CD register to 48-bit round subkey.
module des_pc2
   import des_pkg::*;
(
   input  logic [CD_W-1:0] cd,
   output logic [SK_W-1:0] k
);

   always_comb begin
      k = '0;
      for (int i = 0; i < SK_W; i++) k[SK_W-1-i] = cd[CD_W-PC2_T[i]];
   end

endmodule

// File: rtl/des_key_sched.sv
// DES key schedule: streams ROUNDS subkeys over a valid/ready handshake.
// Define DES_KEY_PARITY_CHECK_EN to flag keys failing per-byte odd parity.
module des_key_sched
   import des_pkg::*;
#(
   parameter int          ROUNDS    = 16,
   parameter logic [15:0] SHIFT_MAP = SHIFT_MAP_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [63:0] key,
   input  logic        decrypt,
   output logic        busy,
   output logic        sk_valid,
   input  logic        sk_ready,
   output logic [47:0] subkey,
   output logic [3:0]  sk_round,
   output logic        done,
   output logic        parity_err
);

   localparam logic [3:0] LAST    = 4'(ROUNDS - 1);
   localparam logic [4:0] DEC_ROT = shift_sum(SHIFT_MAP, ROUNDS);

   state_t            state_q, state_d;
   logic [CD_W-1:0]   cd_q, cd_d;
   logic              dec_q, dec_d;
   logic [SK_W-1:0]   subkey_q, subkey_d, pc2_k;
   logic [3:0]        sk_round_q, sk_round_d;
   logic              sk_valid_q, sk_valid_d;
   logic              done_q, done_d;
   logic              hs, last;
   logic [3:0]        step_idx;
   logic [4:0]        step_amt, rot_amt;

   assign hs       = sk_valid_q & sk_ready;
   assign last     = (sk_round_q == LAST);
   // Decrypt walks rounds backwards, undoing the current round's shift.
   assign step_idx = dec_q ? LAST - sk_round_q : sk_round_q + 4'd1;
   assign step_amt = SHIFT_MAP[step_idx] ? 5'd2 : 5'd1;

   always_comb begin
      rot_amt = 5'd0;
      unique case (state_q)
         S_LOAD:  rot_amt = dec_q ? DEC_ROT
                                  : (SHIFT_MAP[0] ? 5'd2 : 5'd1);
         S_RUN:   if (hs && !last)
                     rot_amt = dec_q ? 5'd28 - step_amt : step_amt;
         default: rot_amt = 5'd0;
      endcase
      cd_d = {rotl28(cd_q[CD_W-1:HALF_W], rot_amt),
              rotl28(cd_q[HALF_W-1:0], rot_amt)};
      if (state_q == S_IDLE && start) cd_d = pc1(key);
   end

   des_pc2 u_pc2 (
      .cd (cd_d),
      .k  (pc2_k)
   );

   always_comb begin
      state_d    = state_q;
      dec_d      = dec_q;
      subkey_d   = subkey_q;
      sk_round_d = sk_round_q;
      sk_valid_d = sk_valid_q;
      done_d     = 1'b0;
      unique case (state_q)
         S_IDLE: if (start) begin
            state_d    = S_LOAD;
            dec_d      = decrypt;
            sk_round_d = '0;
         end
         S_LOAD: begin
            state_d    = S_RUN;
            subkey_d   = pc2_k;
            sk_valid_d = 1'b1;
         end
         S_RUN: if (hs) begin
            if (last) begin
               state_d    = S_DONE;
               sk_valid_d = 1'b0;
               done_d     = 1'b1;
            end else begin
               subkey_d   = pc2_k;
               sk_round_d = sk_round_q + 4'd1;
            end
         end
         S_DONE: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         cd_q       <= '0;
         dec_q      <= 1'b0;
         subkey_q   <= '0;
         sk_round_q <= '0;
         sk_valid_q <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cd_q       <= cd_d;
         dec_q      <= dec_d;
         subkey_q   <= subkey_d;
         sk_round_q <= sk_round_d;
         sk_valid_q <= sk_valid_d;
         done_q     <= done_d;
      end
   end

`ifdef DES_KEY_PARITY_CHECK_EN
   logic parity_err_q, parity_err_d, key_bad;

   always_comb begin
      key_bad = 1'b0;
      for (int i = 0; i < 8; i++) key_bad |= ~^key[8*i +: 8];
      parity_err_d = parity_err_q;
      if (state_q == S_IDLE && start) parity_err_d = key_bad;
   end

   always_ff @(posedge clk) begin
      if (rst) parity_err_q <= 1'b0;
      else     parity_err_q <= parity_err_d;
   end

   assign parity_err = parity_err_q;
`else
   // PC-1 drops the per-byte parity bits; nothing else reads them here.
   logic unused_par_bits;
   assign unused_par_bits = ^{key[56], key[48], key[40], key[32],
                              key[24], key[16], key[8], key[0]};
   assign parity_err = 1'b0;
`endif

   assign busy     = (state_q != S_IDLE);
   assign sk_valid = sk_valid_q;
   assign subkey   = subkey_q;
   assign sk_round = sk_round_q;
   assign done     = done_q;

endmodule

// File: tb/tb_des_key_sched.sv
// Self-checking bench for des_key_sched against a bit-array DES key model.
// Parity expectations follow DES_KEY_PARITY_CHECK_EN.
module tb_des_key_sched;

   localparam int NR = 16;
`ifdef DES_KEY_PARITY_CHECK_EN
   localparam bit PAR_EN = 1'b1;
`else
   localparam bit PAR_EN = 1'b0;
`endif

   localparam logic [63:0] KNOWN = 64'h133457799BBCDFF1;
   localparam logic [47:0] K1    = 48'h1B02EFFC7072;
   localparam logic [47:0] K16   = 48'hCB3D8B0E17F5;

   logic        clk = 1'b0;
   logic        rst, start, decrypt, sk_ready;
   logic [63:0] key;
   logic        busy, sk_valid, done, parity_err;
   logic [47:0] subkey;
   logic [3:0]  sk_round;

   always #5 clk = ~clk;

   des_key_sched dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .key        (key),
      .decrypt    (decrypt),
      .busy       (busy),
      .sk_valid   (sk_valid),
      .sk_ready   (sk_ready),
      .subkey     (subkey),
      .sk_round   (sk_round),
      .done       (done),
      .parity_err (parity_err)
   );

   int PC1 [56] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18,
                    10,2,59,51,43,35,27, 19,11,3,60,52,44,36,
                    63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
                    14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
   int PC2 [48] = '{14,17,11,24,1,5, 3,28,15,6,21,10,
                    23,19,12,4,26,8, 16,7,27,20,13,2,
                    41,52,31,37,47,55, 30,40,51,45,33,48,
                    44,49,39,56,34,53, 46,42,50,36,29,32};
   int SHIFTS [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};

   int n_chk  = 0;
   int n_pass = 0;

   logic [47:0] exp_ks [NR];
   logic [47:0] got    [NR];
   logic [47:0] enc_got [NR];

   typedef struct {
      logic [63:0] key;
      bit          dec;
      int          stall;
      bit          poke;
      logic [47:0] first;
      logic [47:0] last;
   } vec_t;

   vec_t tv [8];

   task automatic chk(input string nm, input logic [63:0] g,
                      input logic [63:0] e);
      n_chk++;
      if (g === e) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, g, e);
   endtask

   // Reference: C/D as bit arrays, cumulative left shift per round.
   task automatic model_ks(input logic [63:0] k);
      bit kb [1:64];
      bit c [28];
      bit d [28];
      int tot, p;
      for (int n = 1; n <= 64; n++) kb[n] = k[64-n];
      for (int i = 0; i < 28; i++) begin
         c[i] = kb[PC1[i]];
         d[i] = kb[PC1[i+28]];
      end
      tot = 0;
      for (int r = 0; r < NR; r++) begin
         tot += SHIFTS[r];
         for (int m = 0; m < 48; m++) begin
            p = PC2[m] - 1;
            exp_ks[r][47-m] = (p < 28) ? c[(p + tot) % 28]
                                       : d[(p - 28 + tot) % 28];
         end
      end
   endtask

   function automatic bit bad_par(input logic [63:0] k);
      for (int i = 0; i < 8; i++)
         if ($countones(k[8*i +: 8]) % 2 == 0) return 1'b1;
      return 1'b0;
   endfunction

   task automatic run_sched(input logic [63:0] k, input bit dec,
                            input int stall, input bit poke);
      int cnt, cyc;
      bit stalled, ep;
      logic [47:0] hk;
      logic [3:0] hr;
      ep = PAR_EN && bad_par(k);
      @(negedge clk);
      key = k; decrypt = dec; start = 1'b1;
      @(negedge clk);
      start = 1'b0; key = ~k; decrypt = ~dec;
      chk("load_no_valid", sk_valid, 0);
      chk("load_busy", busy, 1);
      chk("parity_at_load", parity_err, ep);
      @(negedge clk);
      chk("first_valid_latency", sk_valid, 1);
      cnt = 0; cyc = 0; stalled = 1'b0;
      while (cnt < NR && cyc < 300) begin
         if (stalled) begin
            chk("stall_hold_subkey", subkey, hk);
            chk("stall_hold_round", sk_round, hr);
         end
         start = poke && (cyc == 5);
         if (start) key = {$urandom, $urandom};
         sk_ready = (stall == 0) || ($urandom_range(99) >= stall);
         if (sk_valid && sk_ready) begin
            got[cnt] = subkey;
            chk("round_index", sk_round, cnt);
            cnt++;
            stalled = 1'b0;
         end else begin
            stalled = sk_valid;
            hk = subkey;
            hr = sk_round;
         end
         @(negedge clk);
         cyc++;
      end
      start = 1'b0; sk_ready = 1'b0;
      chk("schedule_complete", cnt, NR);
      chk("done_pulse", done, 1);
      chk("valid_drop", sk_valid, 0);
      chk("parity_held", parity_err, ep);
      @(negedge clk);
      chk("done_clear", done, 0);
      chk("back_idle", busy, 0);
      model_ks(k);
      for (int i = 0; i < NR; i++)
         chk("subkey_seq", got[i], dec ? exp_ks[NR-1-i] : exp_ks[i]);
   endtask

   initial begin
      logic [63:0] rk;
      int cyc;
      rst = 1'b1; start = 1'b0; key = '0; decrypt = 1'b0; sk_ready = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_subkey", subkey, 0);
      chk("rst_round", sk_round, 0);
      chk("rst_valid", sk_valid, 0);
      chk("rst_done", done, 0);
      chk("rst_busy", busy, 0);
      chk("rst_parity", parity_err, 0);
      rst = 1'b0;

      tv[0] = '{KNOWN, 1'b0, 0, 1'b0, K1, K16};
      tv[1] = '{KNOWN, 1'b1, 0, 1'b0, K16, K1};
      tv[2] = '{KNOWN, 1'b0, 50, 1'b0, K1, K16};
      tv[3] = '{KNOWN, 1'b1, 50, 1'b1, K16, K1};
      tv[4] = '{64'h133457799BBCDFF0, 1'b0, 50, 1'b0, K1, K16};
      tv[5] = '{KNOWN, 1'b0, 0, 1'b1, K1, K16};
      rk = {$urandom, $urandom};
      model_ks(rk);
      tv[6] = '{rk, 1'b1, 50, 1'b1, exp_ks[NR-1], exp_ks[0]};
      rk = {$urandom, $urandom};
      model_ks(rk);
      tv[7] = '{rk, 1'b0, 30, 1'b0, exp_ks[0], exp_ks[NR-1]};

      for (int i = 0; i < 8; i++) begin
         run_sched(tv[i].key, tv[i].dec, tv[i].stall, tv[i].poke);
         chk("first_subkey", got[0], tv[i].first);
         chk("last_subkey", got[NR-1], tv[i].last);
         if (i == 0) enc_got = got;
         if (i == 1)
            for (int j = 0; j < NR; j++)
               chk("dec_reverse", got[j], enc_got[NR-1-j]);
      end

      // Reset in the middle of a schedule, then a clean rerun.
      @(negedge clk);
      key = KNOWN; decrypt = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0; sk_ready = 1'b1;
      cyc = 0;
      while (!(sk_valid && sk_round == 4'd7) && cyc < 40) begin
         @(negedge clk);
         cyc++;
      end
      chk("reach_round7", sk_round, 7);
      rst = 1'b1;
      @(negedge clk);
      chk("mid_rst_subkey", subkey, 0);
      chk("mid_rst_round", sk_round, 0);
      chk("mid_rst_valid", sk_valid, 0);
      chk("mid_rst_done", done, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_parity", parity_err, 0);
      rst = 1'b0; sk_ready = 1'b0;
      run_sched(KNOWN, 1'b0, 0, 1'b0);
      chk("rerun_first", got[0], K1);
      chk("rerun_last", got[NR-1], K16);

      // Reset and start together: start must be dropped.
      @(negedge clk);
      rst = 1'b1; start = 1'b1; key = KNOWN;
      @(negedge clk);
      rst = 1'b0; start = 1'b0;
      chk("rst_start_busy", busy, 0);
      repeat (3) @(negedge clk);
      chk("rst_start_no_valid", sk_valid, 0);
      chk("rst_start_idle", busy, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
